p_enc42_if_sync: RTL and testbench

// - Registered priority encoder: reports the index of the highest-set request bit of a.

---
 rtl/p_enc42_if_sync.sv | 44 ++++
 tb/tb_p_enc42_if_sync.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/p_enc42_if_sync.sv
// Registered priority encoder: y is the index of the highest set bit of a,
// valid flags a nonzero sample. Capture on rising clk when en=1.
module p_enc42_if_sync #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           a,
  output logic [$clog2(WIDTH)-1:0]   y,
  output logic                       valid
);

  localparam int OUT_W = $clog2(WIDTH);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_y;
  logic             r_valid;

  // Ascending scan: the last set bit seen is the highest, so it wins.
  // An all-zero vector leaves w_idx at 0, keeping y defined.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) w_idx = OUT_W'(i);
    end
    w_any = |a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_y     <= w_idx;
      r_valid <= w_any;
    end
  end

  assign y     = r_y;
  assign valid = r_valid;

endmodule

// File: tb/tb_p_enc42_if_sync.sv
// Scoreboard bench for p_enc42_if_sync: stimulus pushes expected {valid,y},
// a monitor pops and compares one cycle after each capture edge.
module tb_p_enc42_if_sync;

  localparam int WIDTH = 4;
  localparam int OUT_W = $clog2(WIDTH);

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [OUT_W-1:0] y;
  logic             valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [OUT_W:0] exp_q[$];
  logic [OUT_W-1:0] m_y;
  logic             m_v;

  p_enc42_if_sync #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .a     (a),
    .y     (y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: highest set index found by searching downward from the MSB.
  function automatic int ref_idx(input logic [WIDTH-1:0] v);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i] == 1'b1) return i;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] ay, input logic av,
                       input logic [OUT_W-1:0] ey, input logic ev);
    n_tests++;
    if (ay !== ey || av !== ev) begin
      n_fail++;
      $display("FAIL %s: got y=%0d valid=%0b, expected y=%0d valid=%0b", name, ay, av, ey, ev);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] av, input logic ev);
    @(negedge clk);
    a  = av;
    en = ev;
    if (ev) begin
      m_y = OUT_W'(ref_idx(av));
      m_v = (av != 0);
    end
    exp_q.push_back({m_v, m_y});
  endtask

  initial begin : monitor
    logic [OUT_W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", y, valid, e[OUT_W-1:0], e[OUT_W]);
      end
    end
  end

  initial begin : stim
    int waited;
    rst = 1'b1;
    en  = 1'b1;
    a   = 4'b1111;
    m_y = '0;
    m_v = 1'b0;
    #2;
    check("reset_immediate", y, valid, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", y, valid, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full sweep, one value per cycle
    for (int v = 0; v < 16; v++) drive(4'(v), 1'b1);

    // Priority masking
    drive(4'b1001, 1'b1);
    drive(4'b0101, 1'b1);
    drive(4'b0011, 1'b1);

    // Enable hold
    drive(4'b0100, 1'b1);
    drive(4'b1000, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b1000, 1'b1);

    // Async reset between edges while y=11, valid=1
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_mid", y, valid, 2'd0, 1'b0);
    @(negedge clk);
    check("async_reset_hold", y, valid, 2'd0, 1'b0);
    rst = 1'b0;
    m_y = '0;
    m_v = 1'b0;
    drive(4'b0010, 1'b1);

    // Zero after nonzero
    drive(4'b1000, 1'b1);
    drive(4'b0000, 1'b1);

    // Randomized traffic, en asserted about 75% of the time
    for (int k = 0; k < 300; k++) begin
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
